// File: rtl/rc4_keystream_ctrl.sv
// RC4 sequencer and S-box owner: fill, key schedule, optional drop, then XORs one
// keystream byte onto each byte passed through a single-entry valid/ready stage.
module rc4_keystream_ctrl #(
    parameter int KEY_BYTES = 16,
    parameter int DROP_N    = 0
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   start,
    input  logic                   abort,
    input  logic [8*KEY_BYTES-1:0] key,
    input  logic [5:0]             key_len,
    input  logic                   in_valid,
    input  logic [7:0]             in_data,
    output logic                   in_ready,
    output logic                   out_valid,
    output logic [7:0]             out_data,
    input  logic                   out_ready,
    output logic                   busy,
    output logic                   keyed
);

    // state | meaning
    // IDLE  | waiting for start
    // FILL  | S[n]=n, one entry per cycle
    // KSA   | key schedule, one swap per cycle
    // DROP  | DROP_N discarded keystream steps
    // RUN   | one keystream step per accepted byte
    typedef enum logic [2:0] {ST_IDLE, ST_FILL, ST_KSA, ST_DROP, ST_RUN} state_t;

    localparam int         KW          = (KEY_BYTES > 1) ? $clog2(KEY_BYTES) : 1;
    localparam logic [6:0] KEY_BYTES_7 = 7'(KEY_BYTES);
    localparam logic [9:0] DROP_LOAD   = 10'(DROP_N);

    state_t        r_state;
    state_t        w_state_nxt;
    logic [7:0]    r_sbox [256];
    logic [7:0]    r_key  [KEY_BYTES];
    logic [7:0]    r_i;
    logic [7:0]    r_j;
    logic [KW-1:0] r_kidx;
    logic [KW-1:0] r_klast;
    logic [9:0]    r_drop_cnt;
    logic          r_out_valid;
    logic [7:0]    r_out_data;

    logic          w_start_acc;
    logic          w_accept;
    logic [5:0]    w_klen_eff;
    logic [KW-1:0] w_klast;
    logic [7:0]    w_ksi, w_kj, w_ksj;
    logic [7:0]    w_pi, w_psi, w_pj, w_psj, w_pt, w_ks;

    assign keyed     = (r_state == ST_RUN);
    assign busy      = (r_state == ST_FILL) | (r_state == ST_KSA) | (r_state == ST_DROP);
    assign in_ready  = keyed & (~r_out_valid | out_ready);
    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;

    assign w_start_acc = start & ~abort & ((r_state == ST_IDLE) | (r_state == ST_RUN));
    assign w_accept    = in_valid & in_ready;

    assign w_klen_eff = ((key_len == 6'd0) || ({1'b0, key_len} > KEY_BYTES_7)) ?
                        KEY_BYTES_7[5:0] : key_len;
    assign w_klast    = KW'(w_klen_eff - 6'd1);

    // key-schedule step
    assign w_ksi = r_sbox[r_i];
    assign w_kj  = r_j + w_ksi + r_key[r_kidx];
    assign w_ksj = r_sbox[w_kj];

    // keystream step; output byte is read from the post-swap table
    assign w_pi  = r_i + 8'd1;
    assign w_psi = r_sbox[w_pi];
    assign w_pj  = r_j + w_psi;
    assign w_psj = r_sbox[w_pj];
    assign w_pt  = w_psi + w_psj;
    assign w_ks  = (w_pt == w_pi) ? w_psj :
                   (w_pt == w_pj) ? w_psi : r_sbox[w_pt];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            ST_IDLE: if (start) w_state_nxt = ST_FILL;
            ST_FILL: if (r_i == 8'd255) w_state_nxt = ST_KSA;
            ST_KSA:  if (r_i == 8'd255) w_state_nxt = (DROP_N == 0) ? ST_RUN : ST_DROP;
            ST_DROP: if (r_drop_cnt == 10'd1) w_state_nxt = ST_RUN;
            ST_RUN:  if (start) w_state_nxt = ST_FILL;
            default: w_state_nxt = ST_IDLE;
        endcase
        if (abort) w_state_nxt = ST_IDLE;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_i        <= 8'd0;
            r_j        <= 8'd0;
            r_kidx     <= '0;
            r_klast    <= '0;
            r_drop_cnt <= 10'd0;
            for (int k = 0; k < KEY_BYTES; k++) r_key[k] <= 8'd0;
        end else if (w_start_acc) begin
            r_i     <= 8'd0;
            r_j     <= 8'd0;
            r_kidx  <= '0;
            r_klast <= w_klast;
            for (int k = 0; k < KEY_BYTES; k++) r_key[k] <= key[8*k +: 8];
        end else begin
            unique case (r_state)
                ST_FILL: r_i <= r_i + 8'd1;
                ST_KSA: begin
                    r_i        <= r_i + 8'd1;
                    r_kidx     <= (r_kidx == r_klast) ? '0 : r_kidx + 1'b1;
                    r_j        <= (r_i == 8'd255) ? 8'd0 : w_kj;
                    r_drop_cnt <= DROP_LOAD;
                end
                ST_DROP: begin
                    r_i        <= w_pi;
                    r_j        <= w_pj;
                    r_drop_cnt <= r_drop_cnt - 10'd1;
                end
                ST_RUN: begin
                    if (w_accept) begin
                        r_i <= w_pi;
                        r_j <= w_pj;
                    end
                end
                default: ;
            endcase
        end
    end

    // table contents are undefined after reset and rebuilt by every FILL
    always_ff @(posedge clk) begin
        unique case (r_state)
            ST_FILL: r_sbox[r_i] <= r_i;
            ST_KSA: begin
                r_sbox[r_i]  <= w_ksj;
                r_sbox[w_kj] <= w_ksi;
            end
            ST_DROP: begin
                r_sbox[w_pi] <= w_psj;
                r_sbox[w_pj] <= w_psi;
            end
            ST_RUN: begin
                if (w_accept) begin
                    r_sbox[w_pi] <= w_psj;
                    r_sbox[w_pj] <= w_psi;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_out_valid <= 1'b0;
            r_out_data  <= 8'd0;
        end else if (abort || w_start_acc) begin
            r_out_valid <= 1'b0;
        end else if (w_accept) begin
            r_out_valid <= 1'b1;
            r_out_data  <= in_data ^ w_ks;
        end else if (out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_rc4_keystream_ctrl.sv
// Bench for rc4_keystream_ctrl: known-answer table, stall/abort/reset sequences and
// randomized keys/streams against a textbook RC4 model.
module tb_rc4_keystream_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         reset_n, start, abort, in_valid, out_ready, sel;
    logic [127:0] key;
    logic [5:0]   key_len;
    logic [7:0]   in_data;
    logic         in_ready0, out_valid0, busy0, keyed0;
    logic         in_ready3, out_valid3, busy3, keyed3;
    logic [7:0]   out_data0, out_data3;
    logic         w_in_ready, w_out_valid, w_busy, w_keyed;
    logic [7:0]   w_out_data;

    assign w_in_ready  = sel ? in_ready3  : in_ready0;
    assign w_out_valid = sel ? out_valid3 : out_valid0;
    assign w_busy      = sel ? busy3      : busy0;
    assign w_keyed     = sel ? keyed3     : keyed0;
    assign w_out_data  = sel ? out_data3  : out_data0;

    rc4_keystream_ctrl #(.KEY_BYTES(16), .DROP_N(0)) u_dut0 (
        .clk(clk), .reset_n(reset_n), .start(start), .abort(abort), .key(key),
        .key_len(key_len), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready0),
        .out_valid(out_valid0), .out_data(out_data0), .out_ready(out_ready),
        .busy(busy0), .keyed(keyed0));

    rc4_keystream_ctrl #(.KEY_BYTES(16), .DROP_N(3)) u_dut3 (
        .clk(clk), .reset_n(reset_n), .start(start), .abort(abort), .key(key),
        .key_len(key_len), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready3),
        .out_valid(out_valid3), .out_data(out_data3), .out_ready(out_ready),
        .busy(busy3), .keyed(keyed3));

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic [127:0] key;
        logic [5:0]   klen;
        logic [255:0] pt;
        logic [255:0] ct;
        int           n;
        logic         sel;
        int           pulse_at;
    } vec_t;

    vec_t vt[4];

    task automatic chk(input string nm, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic logic [255:0] s2b(input string s);
        logic [255:0] r;
        r = '0;
        for (int k = 0; k < s.len(); k++) r[8*k +: 8] = s[k];
        return r;
    endfunction

    function automatic logic [255:0] h2b(input logic [255:0] h, input int n);
        logic [255:0] r;
        r = '0;
        for (int k = 0; k < n; k++) r[8*k +: 8] = h[8*(n-1-k) +: 8];
        return r;
    endfunction

    // plain RC4 (optionally dropN), returns n keystream bytes, byte 0 at LSB
    task automatic model(input logic [127:0] k, input logic [5:0] kl, input int drop,
                         input int n, output logic [255:0] ks);
        int s[256];
        int len, i, j, t;
        ks  = '0;
        len = (kl == 6'd0 || kl > 6'd16) ? 16 : int'(kl);
        for (int a = 0; a < 256; a++) s[a] = a;
        j = 0;
        for (int a = 0; a < 256; a++) begin
            j = (j + s[a] + int'(k[8*(a % len) +: 8])) % 256;
            t = s[a]; s[a] = s[j]; s[j] = t;
        end
        i = 0; j = 0;
        for (int c = 0; c < drop + n; c++) begin
            i = (i + 1) % 256;
            j = (j + s[i]) % 256;
            t = s[i]; s[i] = s[j]; s[j] = t;
            t = s[(s[i] + s[j]) % 256];
            if (c >= drop) ks[8*(c-drop) +: 8] = 8'(t);
        end
    endtask

    task automatic do_start(input logic [127:0] k, input logic [5:0] kl, input int exp_cyc,
                            input int pulse_at, input int abort_at);
        int cnt, busy_bad;
        @(posedge clk); #1;
        start = 1'b1; key = k; key_len = kl; in_valid = 1'b0;
        @(posedge clk); #1;
        start = 1'b0;
        key = {$urandom(), $urandom(), $urandom(), $urandom()};
        key_len = 6'($urandom_range(0, 63));
        cnt = 1; busy_bad = 0;
        chk("busy_after_start", 32'(w_busy), 1);
        chk("keyed_after_start", 32'(w_keyed), 0);
        chk("out_valid_after_start", 32'(w_out_valid), 0);
        while (!w_keyed && cnt < 2000) begin
            if (cnt == pulse_at) start = 1'b1;
            if (cnt == abort_at) abort = 1'b1;
            @(posedge clk); #1;
            start = 1'b0; abort = 1'b0;
            cnt++;
            if (abort_at > 0 && cnt == abort_at + 1) begin
                chk("abort_busy", 32'(w_busy), 0);
                chk("abort_keyed", 32'(w_keyed), 0);
                return;
            end
            if (!w_keyed && !w_busy) busy_bad++;
        end
        chk("keyed_cycles", cnt, exp_cyc);
        chk("busy_window", busy_bad, 0);
        chk("busy_when_keyed", 32'(w_busy), 0);
    endtask

    task automatic run_stream(input logic [255:0] pt, input logic [255:0] exp, input int n,
                              input int pv, input int pr, input int stall, input int exp_cyc);
        int ii, oo, cyc, st_left;
        logic seen_first, have_hold;
        logic [7:0] hold_d;
        ii = 0; oo = 0; cyc = 0; st_left = stall; seen_first = 1'b0; have_hold = 1'b0;
        hold_d = 8'd0;
        while (oo < n && cyc < 400) begin
            @(posedge clk); #1;
            if (w_out_valid) seen_first = 1'b1;
            in_valid = (ii < n) && (int'($urandom_range(0, 99)) < pv);
            in_data  = (ii < n) ? pt[8*ii +: 8] : 8'd0;
            if (seen_first && st_left > 0) out_ready = 1'b0;
            else out_ready = (int'($urandom_range(0, 99)) < pr);
            @(negedge clk);
            if (have_hold) begin
                chk("hold_valid", 32'(w_out_valid), 1);
                chk("hold_data", 32'(w_out_data), 32'(hold_d));
            end
            if (seen_first && st_left > 0) begin
                chk("stall_in_ready", 32'(w_in_ready), 0);
                chk("stall_data", 32'(w_out_data), 32'(exp[7:0]));
                st_left--;
            end
            if (in_valid && w_in_ready) ii++;
            have_hold = w_out_valid && !out_ready;
            hold_d    = w_out_data;
            if (w_out_valid && out_ready) begin
                chk("out_byte", 32'(w_out_data), 32'(exp[8*oo +: 8]));
                oo++;
            end
            cyc++;
        end
        in_valid = 1'b0; out_ready = 1'b1;
        if (oo < n) chk("stream_timeout", oo, n);
        if (exp_cyc > 0) chk("stream_cycles", cyc, exp_cyc);
    endtask

    initial begin
        logic [127:0] rk;
        logic [5:0]   rkl;
        logic [255:0] rpt, rks;
        int           rn;

        vt[0] = '{128'(s2b("Key")), 6'd3, s2b("Plaintext"),
                  h2b(256'hBBF316E8D940AF0AD3, 9), 9, 1'b0, 0};
        vt[1] = '{128'(s2b("Wiki")), 6'd4, s2b("pedia"),
                  h2b(256'h1021BF0420, 5), 5, 1'b0, 0};
        vt[2] = '{128'(s2b("Secret")), 6'd6, s2b("Attack at dawn"),
                  h2b(256'h45A01F645FC35B383552544B9BF5, 14), 14, 1'b0, 0};
        vt[3] = '{128'(s2b("Key")), 6'd3, 256'd0, h2b(256'h81B7, 2), 2, 1'b1, 10};

        reset_n = 1'b0; start = 1'b0; abort = 1'b0; key = '0; key_len = 6'd0;
        in_valid = 1'b0; in_data = 8'd0; out_ready = 1'b1; sel = 1'b0;
        #12;
        chk("rst_out_valid", 32'(out_valid0), 0);
        chk("rst_out_data", 32'(out_data0), 0);
        chk("rst_busy_keyed", 32'({busy0, keyed0, busy3, keyed3}), 0);
        chk("rst_in_ready", 32'(in_ready0), 0);
        @(posedge clk); #1;
        reset_n = 1'b1;

        // known-answer table; entry 2 re-keys from RUN with an output pending
        for (int v = 0; v < 4; v++) begin
            sel = vt[v].sel;
            if (v == 2) begin
                @(posedge clk); #1;
                in_valid = 1'b1; in_data = 8'd0; out_ready = 1'b0;
                @(posedge clk); #1;
                in_valid = 1'b0;
                @(negedge clk);
                chk("pending_before_rekey", 32'(w_out_valid), 1);
            end
            do_start(vt[v].key, vt[v].klen, vt[v].sel ? 516 : 513, vt[v].pulse_at, 0);
            run_stream(vt[v].pt, vt[v].ct, vt[v].n, 100, 100, 0, vt[v].n + 1);
        end

        // back-pressure on the first output byte
        sel = 1'b0;
        do_start(vt[0].key, 6'd3, 513, 0, 0);
        run_stream(vt[0].pt, vt[0].ct, 9, 100, 100, 5, 9 + 1 + 5);

        // abort during KSA, stays idle, then clean restart
        do_start(vt[0].key, 6'd3, 0, 0, 300);
        repeat (5) @(posedge clk);
        #1;
        chk("idle_after_abort", 32'({w_busy, w_keyed, w_out_valid}), 0);
        do_start(vt[0].key, 6'd3, 513, 0, 0);
        run_stream(vt[0].pt, vt[0].ct, 9, 100, 100, 0, 10);

        // asynchronous reset mid-RUN with an output pending
        @(posedge clk); #1;
        in_valid = 1'b1; in_data = 8'h55; out_ready = 1'b0;
        @(posedge clk); #1;
        in_valid = 1'b0;
        #2;
        chk("pending_before_reset", 32'(w_out_valid), 1);
        reset_n = 1'b0; start = 1'b1;
        #1;
        chk("async_reset_outputs", 32'({w_out_valid, w_keyed, w_busy}), 0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        reset_n = 1'b1; start = 1'b0; in_valid = 1'b1; out_ready = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            chk("post_reset_idle", 32'({w_in_ready, w_out_valid, w_keyed, w_busy}), 0);
        end
        in_valid = 1'b0;
        do_start(vt[0].key, 6'd3, 513, 0, 0);
        run_stream(vt[0].pt, vt[0].ct, 9, 100, 100, 0, 10);

        // random keys, lengths (incl. 0 and >16) and handshake patterns
        for (int r = 0; r < 8; r++) begin
            sel = (r % 4 == 3);
            rk  = {$urandom(), $urandom(), $urandom(), $urandom()};
            rkl = 6'($urandom_range(0, 20));
            rn  = $urandom_range(1, 32);
            for (int w = 0; w < 8; w++) rpt[32*w +: 32] = $urandom();
            model(rk, rkl, sel ? 3 : 0, rn, rks);
            do_start(rk, rkl, sel ? 516 : 513, 0, 0);
            run_stream(rpt, rpt ^ rks, rn, 70, 60, 0, 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
